pwm_sar_adc: RTL and testbench

Successive-approximation ADC controller built around a PWM DAC and an external comparator. It drives a PWM output whose RC-filtered level is compared against the analog input, runs a binary search one bit at a time, and emits one N-bit code per conversion with a single-cycle valid strobe. It is the producer side of the sample path: `sample` and `sample_valid` connect directly to the moving-average filter's data input and enable.

---
 rtl/pwm_sar_adc.sv | 146 ++++++++++++++
 tb/tb_pwm_sar_adc.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_sar_adc.sv
// pwm_sar_adc: SAR ADC controller using a PWM DAC, an RC filter and an
// external comparator; emits one N-bit code per conversion.
// Ports:
//   clk, reset_n       clock, async active-low reset
//   enable             run conversions back-to-back while high
//   comp_in            async comparator (1: analog input >= filtered PWM)
//   pwm_out            registered PWM drive to the RC filter
//   sample             last completed conversion result
//   sample_valid       one-cycle pulse when sample updates
//   busy               conversion in progress
module pwm_sar_adc #(
   parameter int N              = 12,
   parameter int SETTLE_PERIODS = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         enable,
   input  logic         comp_in,
   output logic         pwm_out,
   output logic [N-1:0] sample,
   output logic         sample_valid,
   output logic         busy
);

   localparam int SW = $clog2(SETTLE_PERIODS) + 1;
   localparam int BW = $clog2(N) + 1;

   localparam logic [N-1:0]  ONE  = N'(1);
   localparam logic [N-1:0]  MSB  = ONE << (N - 1);
   localparam logic [BW-1:0] TOP  = BW'(N - 1);
   localparam logic [SW-1:0] LAST = SW'(SETTLE_PERIODS - 1);

   typedef enum logic {
      IDLE,
      CONVERT
   } state_t;

   state_t        state, state_n;
   logic [N-1:0]  cnt;
   logic [N-1:0]  duty, duty_n;
   logic [N-1:0]  trial, trial_n;
   logic [BW-1:0] bit_idx, bit_idx_n;
   logic [SW-1:0] settle_cnt, settle_cnt_n;
   logic [N-1:0]  sample_n;
   logic          valid_n;
   logic          busy_n;
   logic          comp_m, comp_s;
   logic          b;
   logic [N-1:0]  one_hot;
   logic [N-1:0]  code;

   assign b = (cnt == '1);

   // Bit under test, and the trial with that bit resolved by the comparator.
   assign one_hot = ONE << bit_idx;
   assign code    = comp_s ? trial : (trial & ~one_hot);

   // Period counter, PWM output and comparator synchronizer.
   // duty only changes on B edges, so each period sees a single duty value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         pwm_out <= 1'b0;
         comp_m  <= 1'b0;
         comp_s  <= 1'b0;
      end else begin
         cnt     <= cnt + ONE;
         pwm_out <= (cnt < duty);
         comp_m  <= comp_in;
         comp_s  <= comp_m;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         duty         <= '0;
         trial        <= '0;
         bit_idx      <= '0;
         settle_cnt   <= '0;
         sample       <= '0;
         sample_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_n;
         duty         <= duty_n;
         trial        <= trial_n;
         bit_idx      <= bit_idx_n;
         settle_cnt   <= settle_cnt_n;
         sample       <= sample_n;
         sample_valid <= valid_n;
         busy         <= busy_n;
      end
   end

   always_comb begin
      state_n      = state;
      duty_n       = duty;
      trial_n      = trial;
      bit_idx_n    = bit_idx;
      settle_cnt_n = settle_cnt;
      sample_n     = sample;
      valid_n      = 1'b0;
      busy_n       = busy;
      unique case (state)
         IDLE: begin
            if (b && enable) begin
               state_n      = CONVERT;
               trial_n      = MSB;
               duty_n       = MSB;
               bit_idx_n    = TOP;
               settle_cnt_n = '0;
               busy_n       = 1'b1;
            end
         end
         CONVERT: begin
            if (b) begin
               if (settle_cnt < LAST) begin
                  settle_cnt_n = settle_cnt + SW'(1);
               end else if (bit_idx != '0) begin
                  trial_n      = code | (one_hot >> 1);
                  duty_n       = code | (one_hot >> 1);
                  bit_idx_n    = bit_idx - BW'(1);
                  settle_cnt_n = '0;
               end else begin
                  sample_n = code;
                  valid_n  = 1'b1;
                  duty_n   = code;
                  trial_n  = code;
                  if (enable) begin
                     trial_n      = MSB;
                     duty_n       = MSB;
                     bit_idx_n    = TOP;
                     settle_cnt_n = '0;
                  end else begin
                     state_n = IDLE;
                     busy_n  = 1'b0;
                  end
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pwm_sar_adc.sv
// tb_pwm_sar_adc: self-checking bench for pwm_sar_adc with N=4,
// SETTLE_PERIODS=2, using a boxcar RC-filter model for the comparator.
module tb_pwm_sar_adc;

   localparam int N   = 4;
   localparam int SP  = 2;
   localparam int PER = 16;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         enable = 1'b0;
   logic         comp_in;
   logic         pwm_out;
   logic [N-1:0] sample;
   logic         sample_valid;
   logic         busy;

   logic           use_model = 1'b0;
   logic           comp_level = 1'b0;
   logic [N-1:0]   target = '0;
   logic [PER-1:0] win;

   int errors = 0;
   int checks = 0;
   int since_rst;
   int nval = 0;
   int vt[$];
   logic [N-1:0] expq[$];
   logic prev_valid = 1'b0;
   int hi_cnt[32];

   always #5 clk = ~clk;

   pwm_sar_adc #(.N(N), .SETTLE_PERIODS(SP)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .enable(enable),
      .comp_in(comp_in),
      .pwm_out(pwm_out),
      .sample(sample),
      .sample_valid(sample_valid),
      .busy(busy)
   );

   // Cycle count since reset release; DUT cnt equals since_rst mod 16.
   // win is a 16-clock boxcar of pwm_out standing in for the RC filter.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         since_rst <= 0;
         win       <= '0;
      end else begin
         since_rst <= since_rst + 1;
         win       <= {win[PER-2:0], pwm_out};
      end
   end

   always_comb begin
      comp_in = comp_level;
      if (use_model) comp_in = (int'(target) >= $countones(win));
   end

   // Scoreboard monitor and per-period PWM high-time counter.
   always @(negedge clk) begin : mon
      int p;
      logic [N-1:0] e;
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) hi_cnt[i] = 0;
      end else if (since_rst >= 1) begin
         p = (since_rst - 1) / PER;
         if (p < 32) hi_cnt[p] = hi_cnt[p] + int'(pwm_out);
      end
      if (sample_valid) begin
         nval++;
         vt.push_back(since_rst);
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: sample=%h at cycle %0d, required no pulse", sample, since_rst);
         end else begin
            e = expq.pop_front();
            if (sample !== e) begin
               errors++;
               $display("FAIL sample: got %h, required %h (cycle %0d)", sample, e, since_rst);
            end
         end
         checks++;
         if (prev_valid) begin
            errors++;
            $display("FAIL valid_width: valid high 2 cycles, required 1 (cycle %0d)", since_rst);
         end
      end
      prev_valid = sample_valid;
   end

   task automatic wait_until(input int c);
      int g;
      g = 0;
      while (since_rst < c && g < 5000) begin
         @(negedge clk);
         g++;
      end
      checks++;
      if (since_rst != c) begin
         errors++;
         $display("FAIL wait_until: cycle %0d, required %0d", since_rst, c);
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      vt.delete();
      nval = 0;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      int hi;
      int bz;
      // Power-up reset values.
      repeat (2) @(negedge clk);
      checks++;
      if ({pwm_out, sample, sample_valid, busy} !== '0) begin
         errors++;
         $display("FAIL reset_values: got %b, required 0", {pwm_out, sample, sample_valid, busy});
      end
      vt.delete();
      nval = 0;
      reset_n = 1'b1;
      hi = 0;
      bz = 0;
      repeat (40) begin
         @(negedge clk);
         hi += int'(pwm_out);
         bz += int'(busy);
      end
      checks++;
      if (hi != 0) begin
         errors++;
         $display("FAIL idle_pwm: high clocks %0d, required 0", hi);
      end
      checks++;
      if (bz != 0) begin
         errors++;
         $display("FAIL idle_busy: busy clocks %0d, required 0", bz);
      end
      // Enable rises in IDLE at cycle 40: start at B edge 48, valid at 176.
      comp_level = 1'b1;
      enable = 1'b1;
      expq.push_back(4'hF);
      wait_until(180);
      checks++;
      if (vt.size() != 1 || vt[0] != 176) begin
         errors++;
         $display("FAIL idle_start: valids %0d first at %0d, required 1 at 176", vt.size(), (vt.size() > 0) ? vt[0] : -1);
      end
      checks++;
      if (busy !== 1'b1 || pwm_out !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: busy=%b pwm=%b, required 1 1", busy, pwm_out);
      end
      // Async reset mid-run: outputs clear without a clock edge.
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({pwm_out, sample, sample_valid, busy} !== '0) begin
         errors++;
         $display("FAIL async_reset: got %b, required 0", {pwm_out, sample, sample_valid, busy});
      end
      repeat (3) @(negedge clk);
      enable = 1'b0;
      comp_level = 1'b0;
      reset_n = 1'b1;
   endtask

   task automatic test_tied(input logic lvl, input logic [N-1:0] code);
      comp_level = lvl;
      use_model = 1'b0;
      enable = 1'b1;
      pulse_reset();
      expq.push_back(code);
      expq.push_back(code);
      wait_until(275);
      checks++;
      if (vt.size() != 2 || vt[0] != 144 || vt[1] - vt[0] != 128) begin
         errors++;
         $display("FAIL tied_%b_timing: valids %0d first %0d, required 2 at 144 and 272", lvl, vt.size(), (vt.size() > 0) ? vt[0] : -1);
      end
   endtask

   task automatic test_model();
      int req[8];
      req = '{8, 8, 12, 12, 10, 10, 11, 11};
      target = 4'hA;
      use_model = 1'b1;
      enable = 1'b1;
      pulse_reset();
      expq.push_back(4'hA);
      expq.push_back(4'hA);
      wait_until(145);
      checks++;
      if (vt.size() != 1 || vt[0] != 144) begin
         errors++;
         $display("FAIL model_latency: valids %0d first %0d, required 1 at 144", vt.size(), (vt.size() > 0) ? vt[0] : -1);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (hi_cnt[i + 1] != req[i]) begin
            errors++;
            $display("FAIL pwm_high_p%0d: got %0d, required %0d", i + 1, hi_cnt[i + 1], req[i]);
         end
      end
   endtask

   task automatic test_enable_drop();
      // Second conversion started at 144; drop enable 40 clocks in.
      wait_until(184);
      enable = 1'b0;
      wait_until(280);
      checks++;
      if (nval != 2 || vt[1] != 272) begin
         errors++;
         $display("FAIL drop_valid: valids %0d last %0d, required 2 last 272", nval, vt[vt.size() - 1]);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL drop_busy: got %b, required 0", busy);
      end
      wait_until(500);
      for (int p = 17; p < 31; p += 6) begin
         checks++;
         if (hi_cnt[p] != 10) begin
            errors++;
            $display("FAIL hold_pwm_p%0d: got %0d, required 10", p, hi_cnt[p]);
         end
      end
      checks++;
      if (nval != 2) begin
         errors++;
         $display("FAIL drop_extra: valids %0d, required 2", nval);
      end
   endtask

   task automatic test_reset_mid();
      target = 4'h5;
      use_model = 1'b1;
      enable = 1'b1;
      pulse_reset();
      wait_until(86);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy: got %b, required 1", busy);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || sample_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: busy=%b valid=%b, required 0 0", busy, sample_valid);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (nval != 0) begin
         errors++;
         $display("FAIL mid_abort: valids %0d, required 0", nval);
      end
      vt.delete();
      nval = 0;
      expq.push_back(4'h5);
      reset_n = 1'b1;
      wait_until(150);
      checks++;
      if (nval != 1 || vt[0] != 144) begin
         errors++;
         $display("FAIL restart: valids %0d first %0d, required 1 at 144", nval, (vt.size() > 0) ? vt[0] : -1);
      end
      enable = 1'b0;
   endtask

   initial begin
      test_reset();
      test_tied(1'b1, 4'hF);
      test_tied(1'b0, 4'h0);
      test_model();
      test_enable_drop();
      test_reset_mid();
      repeat (5) @(negedge clk);
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL pending: %0d expected samples never seen, required 0", expq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
